// File: rtl/mux_n_rr_if.sv
//------------------------------------------------------------------------------
// mux_n_rr_if : producer/consumer bundle for the N-input round-robin mux.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mux_n_rr_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SELW = $clog2(N);

    logic              mode;
    logic [SELW-1:0]   sel;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [W-1:0]      out_data;
    logic [SELW-1:0]   out_chan;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_count;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid, out_count
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid, out_count
    );
endinterface

`default_nettype wire

// File: rtl/mux_n_rr.sv
//------------------------------------------------------------------------------
// mux_n_rr : N-input W-bit mux, registered output, direct or round-robin grant.
//            Optional accepted-word counter enabled by macro MUX_N_RR_COUNT_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_n_rr #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mux_n_rr_if.slave   bus
);
    localparam int SELW = $clog2(N);

    logic [W-1:0]    r_out_data;
    logic [SELW-1:0] r_out_chan;
    logic            r_out_valid;
    logic [SELW-1:0] r_ptr;

    logic            w_load_en;
    logic            w_dir_vld;
    logic            w_rr_vld;
    logic [SELW-1:0] w_rr_idx;
    logic            w_grant_vld;
    logic [SELW-1:0] w_grant;
    logic            w_xfer;
    logic [N-1:0]    w_in_ready;
    logic [W-1:0]    w_grant_data;

    assign w_load_en = ~r_out_valid | bus.out_ready;

    // sel values at or above N never match, so they simply produce no grant
    always_comb begin
        w_dir_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ((bus.sel == SELW'(i)) && bus.in_valid[i]) begin
                w_dir_vld = 1'b1;
            end
        end
    end

    // Search begins one past the last round-robin winner and wraps modulo N
    always_comb begin
        int v_idx;
        v_idx    = 0;
        w_rr_vld = 1'b0;
        w_rr_idx = '0;
        for (int k = 1; k <= N; k++) begin
            v_idx = (int'(r_ptr) + k) % N;
            if (!w_rr_vld && bus.in_valid[v_idx]) begin
                w_rr_vld = 1'b1;
                w_rr_idx = SELW'(v_idx);
            end
        end
    end

    always_comb begin
        if (bus.mode) begin
            w_grant_vld = w_rr_vld;
            w_grant     = w_rr_idx;
        end else begin
            w_grant_vld = w_dir_vld;
            w_grant     = bus.sel;
        end
    end

    assign w_xfer = w_grant_vld & w_load_en & ~rst;

    always_comb begin
        w_in_ready = '0;
        if (w_xfer) begin
            w_in_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SELW'(i)) begin
                w_grant_data = bus.in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= SELW'(N - 1);
        end else if (w_xfer) begin
            r_out_data  <= w_grant_data;
            r_out_chan  <= w_grant;
            r_out_valid <= 1'b1;
            if (bus.mode) begin
                r_ptr <= w_grant;
            end
        end else if (bus.out_ready && r_out_valid) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef MUX_N_RR_COUNT_EN
    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 16'h0000;
        end else if (w_xfer) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign bus.out_count = r_count;
`else
    assign bus.out_count = 16'h0000;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;
    assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_n_rr.sv
//------------------------------------------------------------------------------
// tb_mux_n_rr : directed self-checking bench for mux_n_rr (N=4, W=8).
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_n_rr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mux_n_rr_if #(.N(4), .W(8)) bus ();

    mux_n_rr #(.N(4), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic set_data(input logic [7:0] base);
        for (int i = 0; i < 4; i++) bus.in_data[i*8 +: 8] = base + 8'(i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.mode = 1'b1; bus.sel = 2'd0; bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1; set_data(8'h10);
        @(negedge clk); @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b want 0000", bus.in_ready); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", bus.out_data); end
        checks++; if (bus.out_chan !== 2'd0) begin errors++; $display("FAIL rst_chan got %0d want 0", bus.out_chan); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL rel_ready got %b want 0001", bus.in_ready); end
        @(negedge clk); #1;
        checks++; if (bus.out_chan !== 2'd0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h10)
            begin errors++; $display("FAIL rel_out got chan=%0d v=%b d=%h want chan=0 v=1 d=10", bus.out_chan, bus.out_valid, bus.out_data); end
    endtask

    task automatic test_direct();
        bus.in_valid = 4'b0000; do_reset();
        bus.mode = 1'b0; bus.sel = 2'd2; set_data(8'h00); bus.in_data[2*8 +: 8] = 8'hA5;
        bus.in_valid = 4'b1111; bus.out_ready = 1'b1; #1;
        checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL dir_ready got %b want 0100", bus.in_ready); end
        @(negedge clk); #1;
        checks++; if (bus.out_data !== 8'hA5 || bus.out_chan !== 2'd2 || bus.out_valid !== 1'b1)
            begin errors++; $display("FAIL dir_out got d=%h chan=%0d v=%b want d=a5 chan=2 v=1", bus.out_data, bus.out_chan, bus.out_valid); end
        bus.sel = 2'd3; bus.in_valid = 4'b0111; #1;
        checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL dir_nogrant got %b want 0000", bus.in_ready); end
        @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dir_drain got %b want 0", bus.out_valid); end
        // direct transfer of ch2 must not have moved the pointer from 3
        bus.mode = 1'b1; bus.in_valid = 4'b1111; #1;
        checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL dir_ptr got %b want 0001", bus.in_ready); end
    endtask

    task automatic test_rr_fair();
        logic [1:0] exp_seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        bus.in_valid = 4'b0000; do_reset();
        bus.mode = 1'b1; set_data(8'h10); bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (bus.in_ready !== (4'b0001 << exp_seq[i]))
                begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", i, bus.in_ready, 4'b0001 << exp_seq[i]); end
            @(negedge clk); #1;
            checks++; if (bus.out_chan !== exp_seq[i] || bus.out_valid !== 1'b1 || bus.out_data !== 8'h10 + 8'(exp_seq[i]))
                begin errors++; $display("FAIL rr_out[%0d] got chan=%0d v=%b d=%h want chan=%0d v=1 d=%h", i, bus.out_chan, bus.out_valid, bus.out_data, exp_seq[i], 8'h10 + 8'(exp_seq[i])); end
        end
    endtask

    task automatic test_rr_skip();
        logic [1:0] exp_seq [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        bus.in_valid = 4'b0000; do_reset();
        bus.mode = 1'b1; set_data(8'h20); bus.in_valid = 4'b1010; bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++; if (bus.out_chan !== exp_seq[i] || bus.out_data !== 8'h20 + 8'(exp_seq[i]))
                begin errors++; $display("FAIL skip[%0d] got chan=%0d d=%h want chan=%0d", i, bus.out_chan, bus.out_data, exp_seq[i]); end
        end
        bus.in_valid = 4'b0001; #1;
        checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready got %b want 0001", bus.in_ready); end
        @(negedge clk); #1;
        checks++; if (bus.out_chan !== 2'd0 || bus.out_data !== 8'h20)
            begin errors++; $display("FAIL wrap_out got chan=%0d d=%h want chan=0 d=20", bus.out_chan, bus.out_data); end
    endtask

    task automatic test_backpressure();
        bus.in_valid = 4'b0000; do_reset();
        bus.mode = 1'b1; set_data(8'h10); bus.in_valid = 4'b1111; bus.out_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_chan !== 2'd0 || bus.out_data !== 8'h10)
            begin errors++; $display("FAIL bp_load got v=%b chan=%0d d=%h want v=1 chan=0 d=10", bus.out_valid, bus.out_chan, bus.out_data); end
        for (int i = 0; i < 5; i++) begin
            set_data(8'h40 + 8'(i * 16)); bus.in_valid = 4'(4'b0110 ^ i); #1;
            checks++; if (bus.in_ready !== 4'b0000 || bus.out_chan !== 2'd0 || bus.out_data !== 8'h10)
                begin errors++; $display("FAIL bp_stall[%0d] got rdy=%b chan=%0d d=%h want rdy=0000 chan=0 d=10", i, bus.in_ready, bus.out_chan, bus.out_data); end
            @(negedge clk);
        end
        set_data(8'h10); bus.in_valid = 4'b1111; bus.out_ready = 1'b1; #1;
        checks++; if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release got %b want 0010", bus.in_ready); end
        @(negedge clk); #1;
        checks++; if (bus.out_chan !== 2'd1 || bus.out_data !== 8'h11)
            begin errors++; $display("FAIL bp_next got chan=%0d d=%h want chan=1 d=11", bus.out_chan, bus.out_data); end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 4'b0000; do_reset();
        bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1; #1;
        checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready got %b want 0000", bus.in_ready); end
        @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus.out_valid); end
        rst = 1'b0;
    endtask

    task automatic test_counter();
        logic [15:0] exp_cnt;
        bus.in_valid = 4'b0000; do_reset(); #1;
        checks++; if (bus.out_count !== 16'd0) begin errors++; $display("FAIL cnt_init got %0d want 0", bus.out_count); end
        bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        bus.in_valid = 4'b0000; #1;
`ifdef MUX_N_RR_COUNT_EN
        exp_cnt = 16'd10;
`else
        exp_cnt = 16'd0;
`endif
        checks++; if (bus.out_count !== exp_cnt) begin errors++; $display("FAIL cnt_10 got %0d want %0d", bus.out_count, exp_cnt); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.out_count !== 16'd0) begin errors++; $display("FAIL cnt_rst got %0d want 0", bus.out_count); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_direct();
        test_rr_fair();
        test_rr_skip();
        test_backpressure();
        test_reset_mid();
        test_counter();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
